vector_line_gen: RTL



---
 rtl/vector_line_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vector_line_gen.sv
// Bresenham line walker: each accepted segment becomes X/Y word pairs for the dual-channel DAC driver.
// At least one idle cycle between strobes; each write waits for dac_ready; seg_ready is high only while idle.
module vector_line_gen #(
    parameter int BITS  = 12,
    parameter int DWELL = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            seg_valid,
    output logic            seg_ready,
    input  logic [BITS-1:0] x0,
    input  logic [BITS-1:0] y0,
    input  logic [BITS-1:0] x1,
    input  logic [BITS-1:0] y1,
    output logic [BITS-1:0] dac_value,
    output logic            dac_axis,
    output logic            dac_strobe,
    input  logic            dac_ready,
    output logic            busy,
    output logic            done
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SEND_X,
        S_SEND_Y,
        S_DWELL,
        S_STEP
    } state_t;

    state_t state, state_nxt;

    logic [BITS-1:0]        cur_x, cur_y, end_x, end_y;
    logic [BITS-1:0]        cur_x_nxt, cur_y_nxt, end_x_nxt, end_y_nxt;
    logic signed [BITS+1:0] dx, dy, err;
    logic signed [BITS+1:0] dx_nxt, dy_nxt, err_nxt;
    logic                   sx, sy, sx_nxt, sy_nxt;
    logic [DW-1:0]          dwell_cnt, dwell_nxt;
    logic [BITS-1:0]        value_nxt;
    logic                   axis_nxt, strobe_nxt, busy_nxt, done_nxt, seg_ready_nxt;

    // Magnitudes are taken in unsigned BITS so the subtraction never overflows.
    logic                   x_up, y_up;
    logic [BITS-1:0]        adx, ady;

    always_comb begin
        x_up = end_x > cur_x;
        y_up = end_y > cur_y;
        adx  = x_up ? (end_x - cur_x) : (cur_x - end_x);
        ady  = y_up ? (end_y - cur_y) : (cur_y - end_y);
    end

    // Step decision uses the error term from before this step's update.
    logic signed [BITS+2:0] e2, dx_w, dy_w;
    logic                   mv_x, mv_y;
    logic signed [BITS+1:0] err_step;

    always_comb begin
        e2       = $signed({err, 1'b0});
        dx_w     = {dx[BITS+1], dx};
        dy_w     = {dy[BITS+1], dy};
        mv_x     = e2 >= dy_w;
        mv_y     = e2 <= dx_w;
        err_step = err + (mv_x ? dy : '0) + (mv_y ? dx : '0);
    end

    always_comb begin
        state_nxt     = state;
        seg_ready_nxt = seg_ready;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        strobe_nxt    = 1'b0;
        axis_nxt      = dac_axis;
        value_nxt     = dac_value;
        cur_x_nxt     = cur_x;
        cur_y_nxt     = cur_y;
        end_x_nxt     = end_x;
        end_y_nxt     = end_y;
        dx_nxt        = dx;
        dy_nxt        = dy;
        err_nxt       = err;
        sx_nxt        = sx;
        sy_nxt        = sy;
        dwell_nxt     = dwell_cnt;

        case (state)
            S_IDLE: begin
                if (seg_valid && seg_ready) begin
                    cur_x_nxt     = x0;
                    cur_y_nxt     = y0;
                    end_x_nxt     = x1;
                    end_y_nxt     = y1;
                    busy_nxt      = 1'b1;
                    seg_ready_nxt = 1'b0;
                    state_nxt     = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_nxt    = $signed({2'b00, adx});
                dy_nxt    = -$signed({2'b00, ady});
                err_nxt   = $signed({2'b00, adx}) - $signed({2'b00, ady});
                sx_nxt    = x_up;
                sy_nxt    = y_up;
                state_nxt = S_SEND_X;
            end
            S_SEND_X: begin
                if (dac_ready && !dac_strobe) begin
                    value_nxt  = cur_x;
                    axis_nxt   = 1'b1;
                    strobe_nxt = 1'b1;
                    state_nxt  = S_SEND_Y;
                end
            end
            S_SEND_Y: begin
                if (dac_ready && !dac_strobe) begin
                    value_nxt  = cur_y;
                    axis_nxt   = 1'b0;
                    strobe_nxt = 1'b1;
                    if (DWELL > 0) begin
                        dwell_nxt = DW'(DWELL - 1);
                        state_nxt = S_DWELL;
                    end else begin
                        state_nxt = S_STEP;
                    end
                end
            end
            S_DWELL: begin
                if (dwell_cnt == '0) begin
                    state_nxt = S_STEP;
                end else begin
                    dwell_nxt = dwell_cnt - DW'(1);
                end
            end
            S_STEP: begin
                if (cur_x == end_x && cur_y == end_y) begin
                    done_nxt      = 1'b1;
                    busy_nxt      = 1'b0;
                    seg_ready_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end else begin
                    if (mv_x) begin
                        cur_x_nxt = sx ? (cur_x + BITS'(1)) : (cur_x - BITS'(1));
                    end
                    if (mv_y) begin
                        cur_y_nxt = sy ? (cur_y + BITS'(1)) : (cur_y - BITS'(1));
                    end
                    err_nxt   = err_step;
                    state_nxt = S_SEND_X;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            seg_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            dac_strobe <= 1'b0;
            dac_axis   <= 1'b0;
            dac_value  <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            end_x      <= '0;
            end_y      <= '0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            sx         <= 1'b0;
            sy         <= 1'b0;
            dwell_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            seg_ready  <= seg_ready_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            dac_strobe <= strobe_nxt;
            dac_axis   <= axis_nxt;
            dac_value  <= value_nxt;
            cur_x      <= cur_x_nxt;
            cur_y      <= cur_y_nxt;
            end_x      <= end_x_nxt;
            end_y      <= end_y_nxt;
            dx         <= dx_nxt;
            dy         <= dy_nxt;
            err        <= err_nxt;
            sx         <= sx_nxt;
            sy         <= sy_nxt;
            dwell_cnt  <= dwell_nxt;
        end
    end

endmodule
